// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march-style BIST: FSM encoding and the
// address-dependent test pattern.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr0   = 3'd1,
    StRd0   = 3'd2,
    StWr1   = 3'd3,
    StRd1   = 3'd4,
    StFlush = 3'd5,
    StDone  = 3'd6
  } state_e;

  // Base pattern XOR zero-extended address; callers truncate to their data width.
  function automatic logic [63:0] pattern_at(input logic [63:0] base, input logic [63:0] addr);
    return base ^ addr;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare pipeline: captures each issued read, checks it against the RAM
// data one cycle later and tracks error count plus the first failing read.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN = DATA_WIDTH'(8'h55)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  rd_valid_i,
  input  logic                  rd_inv_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_dout_i,
  output logic [ADDR_WIDTH+1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [DATA_WIDTH-1:0] first_err_data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH+1:0] err_q;
  logic [ADDR_WIDTH-1:0] first_addr_q;
  logic [DATA_WIDTH-1:0] first_data_q;
  logic [DATA_WIDTH-1:0] pat;

  assign pat = DATA_WIDTH'(pattern_at(64'(PATTERN), 64'(rd_addr_i)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      valid_q      <= 1'b0;
      exp_q        <= '0;
      addr_q       <= '0;
      err_q        <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
    end else begin
      valid_q <= rd_valid_i;
      exp_q   <= rd_inv_i ? ~pat : pat;
      addr_q  <= rd_addr_i;
      if (valid_q && (ram_dout_i != exp_q)) begin
        err_q <= err_q + (ADDR_WIDTH + 2)'(1);
        if (err_q == '0) begin
          first_addr_q <= addr_q;
          first_data_q <= ram_dout_i;
        end
      end
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_addr_q;
  assign first_err_data_o = first_data_q;

endmodule

// File: rtl/ram_bist.sv
// RAM BIST controller: write P(a), read back, write ~P(a), read back, then
// report pass/fail. All RAM-side outputs come straight from registers.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN = DATA_WIDTH'(8'h55)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  accept;
  logic                  en_q, we_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] pat_d;

  assign pat_d = DATA_WIDTH'(pattern_at(64'(PATTERN), 64'(addr_d)));

  // The address runs through every phase and wraps to 0 on the phase's last cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWr0;
          addr_d  = '0;
          accept  = 1'b1;
        end
      end
      StWr0, StRd0, StWr1, StRd1: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (&addr_q) begin
          unique case (state_q)
            StWr0:   state_d = StRd0;
            StRd0:   state_d = StWr1;
            StWr1:   state_d = StRd1;
            default: state_d = StFlush;
          endcase
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= state_d inside {StWr0, StRd0, StWr1, StRd1};
      we_q    <= state_d inside {StWr0, StWr1};
      din_q   <= (state_d == StWr0) ? pat_d : (state_d == StWr1) ? ~pat_d : '0;
      busy_q  <= state_d inside {StWr0, StRd0, StWr1, StRd1, StFlush};
      done_q  <= (state_d == StDone);
    end
  end

  assign ram_en   = en_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (err_count == '0);

  ram_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .PATTERN   (PATTERN)
  ) u_cmp (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (accept),
    .rd_valid_i      (en_q & ~we_q),
    .rd_inv_i        (state_q == StRd1),
    .rd_addr_i       (addr_q),
    .ram_dout_i      (ram_dout),
    .err_count_o     (err_count),
    .first_err_addr_o(first_err_addr),
    .first_err_data_o(first_err_data)
  );

endmodule

// File: tb/tb_ram_bist.sv
// Scoreboard bench for ram_bist with a behavioural 8x8 RAM that can inject
// a stuck-at bit or address aliasing.
module tb_ram_bist;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [4:0] err;
    logic       pass;
    logic [2:0] faddr;
    logic [7:0] fdata;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       ram_en, ram_we, busy, done, pass;
  logic [2:0] ram_addr, first_err_addr, ram_a;
  logic [7:0] ram_din, ram_dout, first_err_data, dout_q;
  logic [4:0] err_count;
  logic [7:0] mem [8];
  int         fault = 0;

  int checks = 0;
  int errors = 0;

  wr_t  wr_q[$];
  res_t res_q[$];
  wr_t  w;
  res_t r;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  ram_bist dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  // fault 1: dout bit0 stuck at 0; fault 2: addr[2] ignored
  assign ram_a    = (fault == 2) ? {1'b0, ram_addr[1:0]} : ram_addr;
  assign ram_dout = (fault == 1) ? (dout_q & 8'hfe) : dout_q;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_a] <= ram_din;
      else dout_q <= mem[ram_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compares bus writes and final results against the queues.
  always @(negedge clk) begin
    if (busy && !busy_prev) busy_cnt = 1;
    else if (busy) busy_cnt++;
    busy_prev = busy;
    if (ram_en && ram_we) begin
      if (wr_q.size() == 0) chk("unexpected write", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("write addr/data", {ram_addr, ram_din}, {w.addr, w.data});
      end
    end
    if (!ram_en && rst_n) chk("idle bus", {ram_we, ram_addr, ram_din}, 0);
    if (done && !done_prev) begin
      if (res_q.size() == 0) chk("unexpected done", 1, 0);
      else begin
        r = res_q.pop_front();
        chk("result", {err_count, pass, first_err_addr, first_err_data}, r);
        chk("busy cycles", busy_cnt, 33);
      end
    end
    done_prev = done;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_writes(input bit inv);
    for (int a = 0; a < 8; a++) begin
      logic [7:0] p;
      p = 8'h55 ^ 8'(a);
      wr_q.push_back('{addr: 3'(a), data: inv ? ~p : p});
    end
  endtask

  task automatic push_run(input logic [4:0] err, input logic ps, input logic [2:0] fa,
                          input logic [7:0] fd);
    push_writes(1'b0);
    push_writes(1'b1);
    res_q.push_back('{err: err, pass: ps, faddr: fa, fdata: fd});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      cyc(1);
      n++;
    end
    chk("done timeout", done, 1);
    cyc(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ram_en"}, ram_en, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " ram_addr"}, ram_addr, 0);
    chk({tag, " ram_din"}, ram_din, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err_count"}, err_count, 0);
    chk({tag, " first_err_addr"}, first_err_addr, 0);
    chk({tag, " first_err_data"}, first_err_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check_zero("reset");

    // Fault-free run
    push_run(5'd0, 1'b1, 3'd0, 8'h00);
    pulse_start();
    wait_done();

    // Stuck-at-0 on dout bit0
    fault = 1;
    push_run(5'd8, 1'b0, 3'd0, 8'h54);
    pulse_start();
    wait_done();

    // Address aliasing on addr[2]
    fault = 2;
    push_run(5'd8, 1'b0, 3'd0, 8'h51);
    pulse_start();
    wait_done();

    // Start while busy is ignored
    fault = 0;
    push_run(5'd0, 1'b1, 3'd0, 8'h00);
    pulse_start();
    cyc(4);
    pulse_start();
    wait_done();
    cyc(3);
    chk("no restart while busy", busy, 0);

    // Reset mid-test at busy cycle 10
    push_writes(1'b0);
    pulse_start();
    cyc(9);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_zero("abort");
    cyc(5);
    chk("no resume after reset", busy, 0);
    chk("aborted writes drained", wr_q.size(), 0);
    push_run(5'd0, 1'b1, 3'd0, 8'h00);
    pulse_start();
    wait_done();

    // Restart from DONE after a failing run
    fault = 1;
    push_run(5'd8, 1'b0, 3'd0, 8'h54);
    pulse_start();
    wait_done();
    fault = 0;
    push_run(5'd0, 1'b1, 3'd0, 8'h00);
    pulse_start();
    chk("restart done cleared", done, 0);
    chk("restart err_count cleared", err_count, 0);
    chk("restart first_err_addr cleared", first_err_addr, 0);
    chk("restart first_err_data cleared", first_err_data, 0);
    chk("restart busy", busy, 1);
    wait_done();

    chk("write queue empty", wr_q.size(), 0);
    chk("result queue empty", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
